// File: rtl/wb_mul_pkg.sv
// Shared definitions for the Wishbone multiplier accelerator.
// Holds the register map offsets, CTRL/STAT bit positions and the core state encoding.
package wb_mul_pkg;

    localparam logic [7:0] MC_OFF   = 8'h00;
    localparam logic [7:0] MP_OFF   = 8'h04;
    localparam logic [7:0] P0_OFF   = 8'h08;
    localparam logic [7:0] P1_OFF   = 8'h0C;
    localparam logic [7:0] CTRL_OFF = 8'h10;
    localparam logic [7:0] STAT_OFF = 8'h14;

    localparam int CTRL_SIGNED = 0;
    localparam int CTRL_ACC    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        CORE_IDLE = 2'd0,
        CORE_RUN  = 2'd1,
        CORE_DONE = 2'd2
    } core_state_e;

endpackage

// File: rtl/wb_mul_accel_seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle over WIDTH cycles.
// Signed operands are reduced to magnitudes and the product is negated in the DONE cycle.
module seq_mul
    import wb_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 acc,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    input  logic [2*WIDTH-1:0]   p_in,
    output logic [2*WIDTH-1:0]   p_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);

    core_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 neg_q, neg_d;
    logic                 acc_q, acc_d;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   result;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    mcand_d = magnitude(mc, is_signed);
                    prod_d  = {{WIDTH{1'b0}}, magnitude(mp, is_signed)};
                    neg_d   = is_signed && (mc[WIDTH-1] ^ mp[WIDTH-1]);
                    acc_d   = acc;
                    cnt_d   = '0;
                    state_d = CORE_RUN;
                end
            end
            CORE_RUN: begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = CORE_DONE;
            end
            CORE_DONE: state_d = CORE_IDLE;
            default:   state_d = CORE_IDLE;
        endcase

        result = neg_q ? -prod_q : prod_q;
        p_out  = acc_q ? (p_in + result) : result;
    end

    assign busy = (state_q != CORE_IDLE);
    assign done = (state_q == CORE_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CORE_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/wb_mul_accel.sv
// Wishbone slave wrapper around seq_mul: register file, address decode,
// registered single-cycle ack with busy stalling, sticky DONE and level interrupt.
module wb_mul_accel
    import wb_mul_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [7:0] BASE_MASK = 8'hFF
) (
    input  logic        sys_clk,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic [7:0]         adr;
    logic               valid, ready, wr_fire, start;
    logic [WIDTH-1:0]   mp_wr;
    logic [63:0]        p_ext;
    logic [31:0]        rdata;
    logic               core_busy, core_done;
    logic [2*WIDTH-1:0] core_p;
    logic               unused_adr;

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] cur,
                                                     input logic [31:0] data,
                                                     input logic [3:0] sel);
        logic [WIDTH-1:0] r;
        r = cur;
        for (int i = 0; i < WIDTH / 8; i++)
            if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    assign adr        = wbs_adr_i[7:0] & BASE_MASK;
    assign unused_adr = ^wbs_adr_i[31:8];
    assign valid      = wbs_stb_i & wbs_cyc_i;
    assign mp_wr      = merge_lanes(mp_q, wbs_dat_i, wbs_sel_i);

    // Result reads and operand/CTRL writes wait for the core so they never see a half-done op.
    always_comb begin
        ready = 1'b1;
        if (core_busy) begin
            if (wbs_we_i && (adr == MC_OFF || adr == MP_OFF || adr == CTRL_OFF)) ready = 1'b0;
            if (!wbs_we_i && (adr == P0_OFF || adr == P1_OFF)) ready = 1'b0;
        end
    end

    assign ack_d   = valid & ~ack_q & ready;
    assign wr_fire = ack_d & wbs_we_i;
    assign start   = wr_fire && (adr == MP_OFF);

    always_comb begin
        mc_d   = mc_q;
        mp_d   = mp_q;
        ctrl_d = ctrl_q;
        done_d = done_q;
        p_d    = p_q;
        if (wr_fire) begin
            case (adr)
                MC_OFF:   mc_d = merge_lanes(mc_q, wbs_dat_i, wbs_sel_i);
                MP_OFF:   mp_d = mp_wr;
                CTRL_OFF: if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[2:0];
                STAT_OFF: if (wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) done_d = 1'b0;
                default:  ;
            endcase
        end
        if (start) done_d = 1'b0;
        // Completion overrides a same-edge write-1-to-clear.
        if (core_done) begin
            done_d = 1'b1;
            p_d    = core_p;
        end
    end

    always_comb begin
        p_ext = 64'(p_q);
        rdata = DEFAULT_RDATA;
        case (adr)
            MC_OFF:   rdata = 32'(mc_q);
            MP_OFF:   rdata = 32'(mp_q);
            P0_OFF:   rdata = p_ext[31:0];
            P1_OFF:   rdata = p_ext[63:32];
            CTRL_OFF: rdata = 32'(ctrl_q);
            STAT_OFF: begin
                rdata            = '0;
                rdata[STAT_BUSY] = core_busy;
                rdata[STAT_DONE] = done_q;
            end
            default:  ;
        endcase
    end

    assign dat_d = (ack_d && !wbs_we_i) ? rdata : '0;

    always_ff @(posedge sys_clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mc_q   <= '0;
            mp_q   <= '0;
            ctrl_q <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            mc_q   <= mc_d;
            mp_q   <= mp_d;
            ctrl_q <= ctrl_d;
            p_q    <= p_d;
            done_q <= done_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
        end
    end

    seq_mul #(.WIDTH(WIDTH)) u_core (
        .clk       (sys_clk),
        .rst       (wb_rst_i),
        .start     (start),
        .is_signed (ctrl_q[CTRL_SIGNED]),
        .acc       (ctrl_q[CTRL_ACC]),
        .mc        (mc_q),
        .mp        (mp_wr),
        .p_in      (p_q),
        .p_out     (core_p),
        .busy      (core_busy),
        .done      (core_done)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, done_q & ctrl_q[CTRL_IRQ_EN]};

endmodule

// File: tb/tb_wb_mul_accel.sv
// Self-checking bench for wb_mul_accel (WIDTH=32): vector table, timing sequences
// and randomized operations against a plain-arithmetic product model.
module tb_wb_mul_accel;
    import wb_mul_pkg::*;

    localparam int W = 32;

    logic        sys_clk = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  irq;

    int unsigned edge_no = 0;
    int          tests   = 0;
    int          fails   = 0;

    wb_mul_accel #(.WIDTH(W), .BASE_MASK(8'hFF)) dut (
        .sys_clk   (sys_clk),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) edge_no <= edge_no + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rd, output int unsigned ack_at);
        int n;
        n = 0;
        @(negedge sys_clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = {24'h0, adr}; wbs_dat_i = wd; wbs_sel_i = sel;
        do begin
            @(posedge sys_clk); #1; n++;
        end while (wbs_ack_o !== 1'b1 && n < 200);
        check($sformatf("ack_seen@%0h", adr), {63'b0, wbs_ack_o}, 64'd1);
        rd     = wbs_dat_o;
        ack_at = edge_no;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] wd, output int unsigned ack_at);
        logic [31:0] dummy;
        xfer(1'b1, adr, wd, 4'hF, dummy, ack_at);
    endtask

    task automatic rd(input logic [7:0] adr, output logic [31:0] data);
        int unsigned t;
        xfer(1'b0, adr, 32'h0, 4'hF, data, t);
    endtask

    function automatic logic [63:0] model_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic run_op(input logic sgn, input logic acc, input logic [31:0] mc,
                          input logic [31:0] mp, output logic [63:0] p);
        int unsigned t;
        logic [31:0] lo, hi;
        wr(CTRL_OFF, {29'b0, 1'b0, acc, sgn}, t);
        wr(MC_OFF, mc, t);
        wr(MP_OFF, mp, t);
        rd(P0_OFF, lo);
        rd(P1_OFF, hi);
        p = {hi, lo};
    endtask

    typedef struct {
        logic        sgn;
        logic        acc;
        logic [31:0] mc;
        logic [31:0] mp;
        logic [63:0] exp_p;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int unsigned t, t_ack;
        int          n;
        logic [31:0] d;
        logic [63:0] p, p_model, prod;
        logic [31:0] corner[5];
        logic [31:0] a, b;
        logic        sgn, acc, saw_ack;

        vecs[0] = '{1'b0, 1'b0, 32'd7,        32'd6,        64'd42};
        vecs[1] = '{1'b0, 1'b1, 32'd2,        32'd3,        64'd48};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
        vecs[3] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[5] = '{1'b1, 1'b0, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
        vecs[6] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_80000001};
        vecs[7] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        vecs[8] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        64'hC0000002_7FFFFFFE};
        corner  = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};

        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_ack", {63'b0, wbs_ack_o}, 64'd0);
        check("reset_dat", {32'b0, wbs_dat_o}, 64'd0);
        check("reset_irq", {61'b0, irq}, 64'd0);
        @(negedge sys_clk);
        wb_rst_i = 1'b0;
        rd(MC_OFF, d);   check("reset_mc", {32'b0, d}, 64'd0);
        rd(MP_OFF, d);   check("reset_mp", {32'b0, d}, 64'd0);
        rd(P0_OFF, d);   check("reset_p0", {32'b0, d}, 64'd0);
        rd(CTRL_OFF, d); check("reset_ctrl", {32'b0, d}, 64'd0);
        rd(STAT_OFF, d); check("reset_stat", {32'b0, d}, 64'd0);

        // Start timing: BUSY after T, falls together with DONE at T+1+W.
        wr(MC_OFF, 32'd7, t);
        wr(MP_OFF, 32'd6, t);
        @(posedge sys_clk); #1;
        check("busy_t1", {63'b0, dut.core_busy}, 64'd1);
        n = 0;
        while (dut.core_busy === 1'b1 && n < 100) begin
            @(posedge sys_clk); #1; n++;
        end
        check("busy_fall_edge", 64'(edge_no - t), 64'(W + 1));
        rd(STAT_OFF, d); check("stat_done", {32'b0, d}, 64'h2);
        rd(P0_OFF, d);   check("p0_42", {32'b0, d}, 64'd42);
        rd(P1_OFF, d);   check("p1_0", {32'b0, d}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].sgn, vecs[i].acc, vecs[i].mc, vecs[i].mp, p);
            check($sformatf("vec%0d", i), p, vecs[i].exp_p);
        end

        // P0 read issued during BUSY stalls until the cycle after BUSY falls.
        wr(CTRL_OFF, 32'h0, t);
        wr(MC_OFF, 32'd9, t);
        wr(MP_OFF, 32'd9, t);
        @(posedge sys_clk);
        xfer(1'b0, P0_OFF, 32'h0, 4'hF, d, t_ack);
        check("stall_ack_edge", 64'(t_ack - t), 64'(W + 2));
        check("stall_data", {32'b0, d}, 64'd81);
        @(posedge sys_clk); #1;
        check("ack_width", {63'b0, wbs_ack_o}, 64'd0);
        check("dat_idle", {32'b0, wbs_dat_o}, 64'd0);

        // Byte lanes and unmapped space.
        wr(MC_OFF, 32'h0, t);
        xfer(1'b1, MC_OFF, 32'hAABBCCDD, 4'b0001, d, t);
        rd(MC_OFF, d);   check("mc_sel", {32'b0, d}, 64'hDD);
        xfer(1'b1, MC_OFF, 32'h11223344, 4'b0110, d, t);
        rd(MC_OFF, d);   check("mc_sel2", {32'b0, d}, 64'h002233DD);
        rd(8'h40, d);    check("unmapped_rd", {32'b0, d}, 64'hDEADBEEF);
        wr(8'h40, 32'h12345678, t);
        rd(MC_OFF, d);   check("unmapped_wr_noeffect", {32'b0, d}, 64'h002233DD);

        // Interrupt: rises with DONE at T+1+W, cleared by W1C.
        wr(CTRL_OFF, 32'h4, t);
        wr(MC_OFF, 32'd3, t);
        wr(MP_OFF, 32'd4, t);
        check("irq_cleared_at_start", {61'b0, irq}, 64'd0);
        n = 0;
        while (irq === 3'b000 && n < 100) begin
            @(posedge sys_clk); #1; n++;
        end
        check("irq_edge", 64'(edge_no - t), 64'(W + 1));
        check("irq_val", {61'b0, irq}, 64'd1);
        wr(STAT_OFF, 32'h2, t);
        check("irq_w1c", {61'b0, irq}, 64'd0);
        rd(STAT_OFF, d); check("stat_w1c", {32'b0, d}, 64'd0);
        rd(P0_OFF, d);   check("irq_p0", {32'b0, d}, 64'd12);

        // Randomized operations against the arithmetic model.
        p_model = '0;
        for (int i = 0; i < 24; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            sgn = 1'($urandom_range(0, 1));
            acc = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            prod    = model_prod(sgn, a, b);
            p_model = acc ? (p_model + prod) : prod;
            run_op(sgn, acc, a, b, p);
            check($sformatf("rand%0d s%0d a%0d %h*%h", i, sgn, acc, a, b), p, p_model);
        end

        // Reset mid-operation with a stalled P0 read pending.
        wr(CTRL_OFF, 32'h1, t);
        wr(MC_OFF, 32'd5, t);
        wr(MP_OFF, 32'd5, t);
        @(posedge sys_clk);
        @(negedge sys_clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = {24'h0, P0_OFF}; wbs_sel_i = 4'hF;
        saw_ack = 1'b0;
        while (edge_no < t + 10) begin
            @(posedge sys_clk); #1;
            if (wbs_ack_o) saw_ack = 1'b1;
        end
        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        #1;
        check("rst_busy", {63'b0, dut.core_busy}, 64'd0);
        repeat (2) begin
            @(posedge sys_clk); #1;
            if (wbs_ack_o) saw_ack = 1'b1;
        end
        check("rst_no_ack", {63'b0, saw_ack}, 64'd0);
        @(negedge sys_clk);
        wb_rst_i = 1'b0;
        rd(STAT_OFF, d); check("rst_stat", {32'b0, d}, 64'd0);
        rd(P0_OFF, d);   check("rst_p0", {32'b0, d}, 64'd0);
        rd(P1_OFF, d);   check("rst_p1", {32'b0, d}, 64'd0);
        rd(CTRL_OFF, d); check("rst_ctrl", {32'b0, d}, 64'd0);
        rd(MC_OFF, d);   check("rst_mc", {32'b0, d}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
